// File: rtl/step_pattern_source.sv
// rtl/step_pattern_source.sv - debounced push-button stepper presenting a loaded bit pattern one bit per press
module step_pattern_source #(
  parameter int PAT_W     = 16,
  parameter int IDX_W     = 5,
  parameter int DB_CYCLES = 500000,
  parameter int DB_W      = 19
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             key_n,
  input  logic             load,
  input  logic             loop_mode,
  input  logic [PAT_W-1:0] pattern,
  input  logic [IDX_W-1:0] pat_len,
  output logic             w,
  output logic             w_valid,
  output logic             step_pulse,
  output logic [IDX_W-1:0] bit_idx,
  output logic [1:0]       state_o,
  output logic             done
);

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    READY = 2'b01,
    PLAY  = 2'b10,
    DONE  = 2'b11
  } state_t;

  logic            sync1, sync2;
  logic            db_level, db_prev;
  logic [DB_W-1:0] db_cnt;

  // Two-flop synchroniser, then a stability counter; db_prev delays the level so
  // the press strobe lands one cycle after the debounced fall.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      sync1      <= 1'b1;
      sync2      <= 1'b1;
      db_level   <= 1'b1;
      db_prev    <= 1'b1;
      db_cnt     <= '0;
      step_pulse <= 1'b0;
    end else begin
      sync1      <= key_n;
      sync2      <= sync1;
      db_prev    <= db_level;
      step_pulse <= db_prev & ~db_level;
      if (sync2 != db_level) begin
        if (db_cnt == DB_W'(DB_CYCLES - 1)) begin
          db_level <= sync2;
          db_cnt   <= '0;
        end else begin
          db_cnt <= db_cnt + DB_W'(1);
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  state_t           state, state_n;
  logic [PAT_W-1:0] pattern_reg, pattern_n;
  logic [IDX_W-1:0] len_reg, len_n;
  logic [IDX_W-1:0] idx_n;
  logic             w_n, w_valid_n;
  logic [IDX_W-1:0] eff_len;
  logic [PAT_W-1:0] shifted;

  assign eff_len = (pat_len == '0 || pat_len > IDX_W'(PAT_W)) ? IDX_W'(PAT_W) : pat_len;
  assign shifted = pattern_reg << bit_idx;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state       <= EMPTY;
      pattern_reg <= '0;
      len_reg     <= IDX_W'(PAT_W);
      bit_idx     <= '0;
      w           <= 1'b0;
      w_valid     <= 1'b0;
    end else begin
      state       <= state_n;
      pattern_reg <= pattern_n;
      len_reg     <= len_n;
      bit_idx     <= idx_n;
      w           <= w_n;
      w_valid     <= w_valid_n;
    end
  end

  always_comb begin
    state_n   = state;
    pattern_n = pattern_reg;
    len_n     = len_reg;
    idx_n     = bit_idx;
    w_n       = w;
    w_valid_n = 1'b0;
    if (load) begin
      state_n   = READY;
      pattern_n = pattern;
      len_n     = eff_len;
      idx_n     = '0;
      w_n       = 1'b0;
    end else if (step_pulse && (state == READY || state == PLAY)) begin
      w_n       = shifted[PAT_W-1];
      w_valid_n = 1'b1;
      if (bit_idx != len_reg - IDX_W'(1)) begin
        idx_n   = bit_idx + IDX_W'(1);
        state_n = PLAY;
      end else if (loop_mode) begin
        idx_n   = '0;
        state_n = PLAY;
      end else begin
        state_n = DONE;
      end
    end
  end

  assign state_o = state;
  assign done    = (state == DONE);

endmodule

// File: tb/tb_step_pattern_source.sv
// tb/tb_step_pattern_source.sv - table-driven bench for step_pattern_source
module tb_step_pattern_source;

  logic        clock = 1'b0;
  logic        resetn, key_n, load, loop_mode;
  logic [15:0] pattern;
  logic [4:0]  pat_len;
  logic        w, w_valid, step_pulse, done;
  logic [4:0]  bit_idx;
  logic [1:0]  state_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  step_pattern_source #(.PAT_W(16), .IDX_W(5), .DB_CYCLES(4), .DB_W(3)) dut (
    .clock(clock), .resetn(resetn), .key_n(key_n), .load(load), .loop_mode(loop_mode),
    .pattern(pattern), .pat_len(pat_len), .w(w), .w_valid(w_valid),
    .step_pulse(step_pulse), .bit_idx(bit_idx), .state_o(state_o), .done(done)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          is_load;
    logic [15:0] pat;
    logic [4:0]  len;
    bit          lp;
    int          exp_nv;
    logic        exp_w;
    logic [4:0]  exp_idx;
    logic [1:0]  exp_st;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit is_load, logic [15:0] pat, logic [4:0] len, bit lp,
                              int nv, logic ew, logic [4:0] idx, logic [1:0] st);
    vec_t v;
    v.is_load = is_load; v.pat = pat; v.len = len; v.lp = lp;
    v.exp_nv = nv; v.exp_w = ew; v.exp_idx = idx; v.exp_st = st;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic do_load(input logic [15:0] p, input logic [4:0] l, input logic lp);
    pattern = p; pat_len = l; loop_mode = lp; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  // Full press-and-release; counts w_valid cycles over the whole window.
  task automatic press(output int nv);
    nv = 0;
    key_n = 1'b0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (w_valid) nv++;
    end
    key_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (w_valid) nv++;
    end
  endtask

  int pulses, first_at, fall_at, nv;
  bit seen;

  task automatic tick_count();
    tick();
    if (step_pulse) begin
      if (pulses == 0) first_at = cyc;
      pulses++;
    end
  endtask

  initial begin
    resetn = 1'b0; key_n = 1'b1; load = 1'b0; loop_mode = 1'b0;
    pattern = 16'h0; pat_len = 5'd0;

    // Reset with a bouncing button
    tick(); key_n = 1'b0;
    tick(); key_n = 1'b1;
    check("rst_w", w, 0);
    check("rst_w_valid", w_valid, 0);
    check("rst_step_pulse", step_pulse, 0);
    check("rst_bit_idx", bit_idx, 0);
    check("rst_state", state_o, 2'b00);
    check("rst_done", done, 0);
    resetn = 1'b1;
    repeat (3) tick();

    // Press bounce: low 3, high 1, low 10
    pulses = 0; first_at = 0;
    key_n = 1'b0; repeat (3) tick_count();
    key_n = 1'b1; tick_count();
    key_n = 1'b0; fall_at = cyc;
    repeat (10) tick_count();
    check("db_press_pulses", pulses, 1);
    check("db_press_latency", first_at - fall_at, 7);
    // Release bounce: high 2, low 1, high 10
    pulses = 0;
    key_n = 1'b1; repeat (2) tick_count();
    key_n = 1'b0; tick_count();
    key_n = 1'b1; repeat (10) tick_count();
    check("db_release_pulses", pulses, 0);
    check("empty_step_ignored", state_o, 2'b00);

    // One-shot: F0A5, len 8
    vecs.push_back(mk(1, 16'hF0A5, 5'd8, 0, 0, 0, 0, 2'b01));
    for (int k = 0; k < 8; k++)
      vecs.push_back(mk(0, 0, 0, 0, 1, (k < 4), (k < 7) ? 5'(k + 1) : 5'd7, (k < 7) ? 2'b10 : 2'b11));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 5'd7, 2'b11));
    // Loop: C000, len 2
    vecs.push_back(mk(1, 16'hC000, 5'd2, 1, 0, 0, 0, 2'b01));
    for (int k = 0; k < 5; k++)
      vecs.push_back(mk(0, 0, 0, 1, 1, 1, (k % 2 == 0) ? 5'd1 : 5'd0, 2'b10));
    // pat_len 0 means full width
    vecs.push_back(mk(1, 16'hAAAA, 5'd0, 0, 0, 0, 0, 2'b01));
    for (int k = 0; k < 16; k++)
      vecs.push_back(mk(0, 0, 0, 0, 1, (k % 2 == 0), (k < 15) ? 5'(k + 1) : 5'd15, (k < 15) ? 2'b10 : 2'b11));

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].is_load) begin
        do_load(vecs[i].pat, vecs[i].len, vecs[i].lp);
        check($sformatf("v%0d_load_w_valid", i), w_valid, 0);
      end else begin
        loop_mode = vecs[i].lp;
        press(nv);
        check($sformatf("v%0d_nvalid", i), nv, vecs[i].exp_nv);
      end
      check($sformatf("v%0d_w", i), w, vecs[i].exp_w);
      check($sformatf("v%0d_bit_idx", i), bit_idx, vecs[i].exp_idx);
      check($sformatf("v%0d_state", i), state_o, vecs[i].exp_st);
      check($sformatf("v%0d_done", i), done, (vecs[i].exp_st == 2'b11));
    end

    // Load coincident with step_pulse in PLAY
    do_load(16'hF0A5, 5'd8, 0);
    press(nv);
    check("prio_pre_state", state_o, 2'b10);
    key_n = 1'b0; seen = 0;
    for (int i = 0; i < 14 && !seen; i++) begin
      tick();
      if (step_pulse) seen = 1;
    end
    check("prio_pulse_seen", seen, 1);
    load = 1'b1;
    tick();
    load = 1'b0;
    check("prio_w_valid", w_valid, 0);
    check("prio_bit_idx", bit_idx, 0);
    check("prio_state", state_o, 2'b01);
    tick();
    check("prio_w_valid_after", w_valid, 0);
    key_n = 1'b1;
    repeat (10) tick();

    // Reset coincident with load
    load = 1'b1; resetn = 1'b0;
    tick();
    check("rst_load_state", state_o, 2'b00);
    load = 1'b0; resetn = 1'b1;
    tick();
    check("rst_load_state_after", state_o, 2'b00);
    check("rst_load_idx", bit_idx, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
